// File: rtl/writeback_stage.sv
// writeback_stage
// Final stage of the 32-bit MIPS core. It registers M-stage results into the
// W pipeline register, extracts and extends load data, selects the ALU or
// load result, drives the register file write port, exports W-stage state to
// the forwarding unit and counts retired instructions.
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   stallw, flushw      hold W / load a bubble into W (flush wins over stall)
//   validm .. writeregm M-stage instruction fields
//   we3, wa3, wd3       register file write port (address/data zeroed when idle)
//   regwritew           qualified write flag for forwarding
//   writeregw, resultw  unqualified W destination and result for forwarding
//   misalignw           W holds an odd-address halfword load (write suppressed)
//   instret             retired-instruction count, wraps modulo 2^CNT_W
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallw,
  input  logic             flushw,
  input  logic             validm,
  input  logic             regwritem,
  input  logic             memtoregm,
  input  logic [2:0]       loadtypem,
  input  logic [31:0]      aluoutm,
  input  logic [31:0]      readdatam,
  input  logic [4:0]       writeregm,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [31:0]      wd3,
  output logic             regwritew,
  output logic [4:0]       writeregw,
  output logic [31:0]      resultw,
  output logic             misalignw,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic             validw;
  logic             regwrite_q;
  logic             memtoregw;
  logic [2:0]       loadtypew;
  logic [31:0]      aluoutw;
  logic [31:0]      readdataw;
  logic [4:0]       writereg_q;
  logic             misalign_q;
  logic [CNT_W-1:0] instret_q;

  logic             misalign_d;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;
  logic [31:0]      result;
  logic             wr_ok;
  logic             we;

  // Odd-address halfword loads are trapped later; they must neither write
  // nor count as retired.
  assign misalign_d = validm & memtoregm &
                      ((loadtypem == LT_LH) | (loadtypem == LT_LHU)) &
                      aluoutm[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      validw     <= 1'b0;
      regwrite_q <= 1'b0;
      memtoregw  <= 1'b0;
      loadtypew  <= 3'b000;
      aluoutw    <= 32'h0;
      readdataw  <= 32'h0;
      writereg_q <= 5'h0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else if (flushw) begin
      // Only the fields that qualify a write are cleared; the rest are dead.
      validw     <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stallw) begin
      validw     <= validm;
      regwrite_q <= regwritem;
      memtoregw  <= memtoregm;
      loadtypew  <= loadtypem;
      aluoutw    <= aluoutm;
      readdataw  <= readdatam;
      writereg_q <= writeregm;
      misalign_q <= misalign_d;
      if (validm && !misalign_d)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    byte_sel = 8'h0;
    case (aluoutw[1:0])
      2'd0:    byte_sel = readdataw[7:0];
      2'd1:    byte_sel = readdataw[15:8];
      2'd2:    byte_sel = readdataw[23:16];
      default: byte_sel = readdataw[31:24];
    endcase
  end

  assign half_sel = aluoutw[1] ? readdataw[31:16] : readdataw[15:0];

  always_comb begin
    load_data = readdataw;
    case (loadtypew)
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h0, byte_sel};
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0, half_sel};
      default: load_data = readdataw;
    endcase
  end

  assign result = memtoregw ? load_data : aluoutw;
  assign wr_ok  = validw & regwrite_q & ~misalign_q;
  assign we     = wr_ok & (writereg_q != 5'd0);

  // The read ports bypass on address match regardless of we3, so an idle
  // write port must present address 0 with data 0.
  assign we3       = we;
  assign wa3       = we ? writereg_q : 5'd0;
  assign wd3       = we ? result : 32'h0;
  assign regwritew = wr_ok;
  assign writeregw = writereg_q;
  assign resultw   = result;
  assign misalignw = misalign_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, stallw, flushw;
  logic             validm, regwritem, memtoregm;
  logic [2:0]       loadtypem;
  logic [31:0]      aluoutm, readdatam;
  logic [4:0]       writeregm;
  logic             we3, regwritew, misalignw;
  logic [4:0]       wa3, writeregw;
  logic [31:0]      wd3, resultw;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stallw(stallw), .flushw(flushw),
    .validm(validm), .regwritem(regwritem), .memtoregm(memtoregm),
    .loadtypem(loadtypem), .aluoutm(aluoutm), .readdatam(readdatam),
    .writeregm(writeregm), .we3(we3), .wa3(wa3), .wd3(wd3),
    .regwritew(regwritew), .writeregw(writeregw), .resultw(resultw),
    .misalignw(misalignw), .instret(instret)
  );

  int checks = 0;
  int failures = 0;

  // Reference: the instruction currently held in W, plus a retire count.
  bit          m_valid, m_rw, m_mem, m_mis, m_dead;
  int unsigned m_lt, m_alu, m_rd, m_wr;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned load_value(int unsigned lt, int unsigned addr, int unsigned rd);
    int unsigned b, h;
    b = (rd >> (8 * (addr % 4))) % 256;
    h = (rd >> (16 * ((addr / 2) % 2))) % 65536;
    case (lt)
      1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      2: return b;
      3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return h;
      default: return rd;
    endcase
  endfunction

  task automatic model_edge();
    bit mis;
    if (reset) begin
      m_valid = 0; m_rw = 0; m_mem = 0; m_mis = 0; m_dead = 0;
      m_lt = 0; m_alu = 0; m_rd = 0; m_wr = 0; m_cnt = 0;
    end else if (flushw) begin
      m_valid = 0; m_rw = 0; m_mis = 0; m_dead = 1;
    end else if (!stallw) begin
      mis = validm && memtoregm && (loadtypem == 3 || loadtypem == 4) && aluoutm[0];
      m_valid = validm; m_rw = regwritem; m_mem = memtoregm; m_mis = mis;
      m_lt = loadtypem; m_alu = aluoutm; m_rd = readdatam; m_wr = writeregm;
      m_dead = 0;
      if (validm && !mis) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic check_model();
    int unsigned res;
    bit rw_q, we;
    res  = m_mem ? load_value(m_lt, m_alu, m_rd) : m_alu;
    rw_q = m_valid && m_rw && !m_mis;
    we   = rw_q && (m_wr != 0);
    chk("we3", 32'(we3), 32'(we));
    chk("wa3", 32'(wa3), we ? m_wr : 0);
    chk("wd3", wd3, we ? res : 0);
    chk("regwritew", 32'(regwritew), 32'(rw_q));
    chk("misalignw", 32'(misalignw), 32'(m_mis));
    chk("instret", 32'(instret), m_cnt);
    if (!m_dead) begin
      chk("writeregw", 32'(writeregw), m_wr);
      chk("resultw", resultw, res);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_m(input bit v, input bit rw, input bit mem, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
    validm = v; regwritem = rw; memtoregm = mem; loadtypem = lt;
    aluoutm = alu; readdatam = rd; writeregm = wr;
  endtask

  logic [31:0] lb_exp [4];
  logic [31:0] lbu_exp[4];

  initial begin
    lb_exp  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    lbu_exp = '{32'h01, 32'h7F, 32'hFF, 32'h80};
    reset = 1; stallw = 0; flushw = 0;
    set_m(1, 1, 1, 3'd0, 32'h104, 32'h12345678, 5'd3);
    tick();
    chk("rst_we3", 32'(we3), 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_instret", 32'(instret), 0);
    reset = 0;

    set_m(1, 1, 1, 3'd0, 32'h100, 32'hDEADBEEF, 5'd8);
    tick();
    chk("lw_we3", 32'(we3), 1);
    chk("lw_wa3", 32'(wa3), 8);
    chk("lw_wd3", wd3, 32'hDEADBEEF);
    chk("lw_instret", 32'(instret), 1);

    for (int i = 0; i < 4; i++) begin
      set_m(1, 1, 1, 3'd1, 32'h200 + i, 32'h80FF7F01, 5'd9);
      tick();
      chk("lb_wd3", wd3, lb_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      set_m(1, 1, 1, 3'd2, 32'h300 + i, 32'h80FF7F01, 5'd10);
      tick();
      chk("lbu_wd3", wd3, lbu_exp[i]);
    end
    chk("bytes_instret", 32'(instret), 9);

    set_m(1, 1, 1, 3'd3, 32'h2, 32'h8001F00F, 5'd11);
    tick();
    chk("lh_wd3", wd3, 32'hFFFF8001);
    set_m(1, 1, 1, 3'd4, 32'h0, 32'h8001F00F, 5'd12);
    tick();
    chk("lhu_wd3", wd3, 32'h0000F00F);
    set_m(1, 1, 1, 3'd3, 32'h1, 32'h8001F00F, 5'd13);
    tick();
    chk("mis_flag", 32'(misalignw), 1);
    chk("mis_we3", 32'(we3), 0);
    chk("mis_wa3", 32'(wa3), 0);
    chk("mis_wd3", wd3, 0);
    chk("mis_instret", 32'(instret), 11);

    set_m(1, 1, 0, 3'd0, 32'h1234, 32'h0, 5'd0);
    tick();
    chk("r0_we3", 32'(we3), 0);
    chk("r0_wa3", 32'(wa3), 0);
    chk("r0_wd3", wd3, 0);
    chk("r0_instret", 32'(instret), 12);

    set_m(1, 1, 0, 3'd0, 32'hAAAA, 32'h0, 5'd5);
    tick();
    stallw = 1;
    set_m(1, 1, 0, 3'd0, 32'h5555, 32'h0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_wa3", 32'(wa3), 5);
      chk("stall_wd3", wd3, 32'hAAAA);
      chk("stall_instret", 32'(instret), 13);
    end
    flushw = 1;
    tick();
    chk("flush_we3", 32'(we3), 0);
    chk("flush_regwritew", 32'(regwritew), 0);
    chk("flush_instret", 32'(instret), 13);
    flushw = 0; stallw = 0;

    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      set_m(1, 1, 0, 3'd0, 32'(i), 32'h0, 5'(i + 1));
      tick();
    end
    chk("wrap_instret", 32'(instret), 0);

    set_m(1, 1, 0, 3'd0, 32'hBEEF, 32'h0, 5'd7);
    tick();
    stallw = 1;
    tick();
    reset = 1;
    tick();
    chk("rst_stall_we3", 32'(we3), 0);
    chk("rst_stall_wa3", 32'(wa3), 0);
    chk("rst_stall_writeregw", 32'(writeregw), 0);
    chk("rst_stall_resultw", resultw, 0);
    chk("rst_stall_instret", 32'(instret), 0);
    reset = 0; stallw = 0;

    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      flushw = ($urandom_range(0, 9) == 0);
      stallw = ($urandom_range(0, 4) == 0);
      set_m(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
